// File: rtl/ss_rd_chan_pkg.sv
`default_nettype none
// ============================================================================
// ss_rd_chan_pkg : state encodings and descriptor constants for ss_rd_chan
// Rev 1.0
// ============================================================================
package ss_rd_chan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WAIT_ROOM = 3'd2,
    ST_BURST     = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } ss_state_e;

  localparam logic [1:0] c_adr_next = 2'd0;
  localparam logic [1:0] c_adr_dc   = 2'd1;
  localparam logic [1:0] c_adr_buf  = 2'd2;
  localparam logic [1:0] c_adr_len  = 2'd3;

  localparam int c_dc_null = 6;

  // ceil(len/8) held in 21 bits; the largest lengths wrap to zero beats
  function automatic logic [20:0] beat_count(input logic [23:0] len);
    logic [24:0] sum;
    sum = {1'b0, len} + 25'd7;
    return sum[23:3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ss_rd_chan_fifo.sv
`default_nettype none
// ============================================================================
// ss_fifo : synchronous FIFO with free-space count and flush
// Rev 1.0
// ============================================================================
module ss_fifo #(
  parameter int WIDTH = 65,
  parameter int AW    = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      free
);

  localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign empty   = (w_count == '0);
  assign full    = w_count[AW];
  assign free    = c_depth - w_count;
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge wb_clk_i) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ss_rd_chan.sv
`default_nettype none
// ============================================================================
// ss_rd_chan : source-side DMA read channel, descriptor -> 64-bit WB bursts -> stream
// Rev 1.0
// ============================================================================
module ss_rd_chan
  import ss_rd_chan_pkg::*;
#(
  parameter int BURST_MAX = 8,
  parameter int FIFO_AW   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ss_we,
  input  logic [1:0]  ss_adr,
  input  logic [31:0] ss_dat,
  input  logic [23:0] ss_dc,
  input  logic        ss_done,
  output logic        c_done,
  output logic        ch_err,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic        m_cab,
  output logic [3:0]  m_sel,
  output logic [31:0] m_adr,
  input  logic [31:0] m_dat_i,
  input  logic [31:0] m_dat64_i,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic        m_rty,
  output logic        st_valid,
  output logic [63:0] st_data,
  output logic        st_last,
  input  logic        st_ready
);

  localparam logic [20:0] c_burst_max = 21'(BURST_MAX);

  ss_state_e        r_state;
  ss_state_e        w_state_nxt;
  logic [28:0]      r_addr;
  logic [23:0]      r_len;
  logic [20:0]      r_remain;
  logic [20:0]      r_left;
  logic             r_cyc;
  logic             r_c_done;
  logic             r_ch_err;
  logic             w_cyc_nxt;
  logic             w_load_base;
  logic             w_load_len;
  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [20:0]      w_beats;
  logic [20:0]      w_n;
  logic [20:0]      w_free_ext;
  logic [FIFO_AW:0] w_free;
  logic [64:0]      w_dout;
  logic             w_unused_ok;

  assign w_beats    = beat_count(r_len);
  assign w_n        = (r_remain < c_burst_max) ? r_remain : c_burst_max;
  assign w_free_ext = 21'(w_free);
  assign w_push     = (r_state == ST_BURST) & m_ack & ~m_err & ~m_rty;
  assign w_pop      = st_valid & st_ready;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_load_base = 1'b0;
    w_load_len  = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ss_we) begin
          case (ss_adr)
            c_adr_buf: w_load_base = 1'b1;
            c_adr_len: begin
              w_load_len  = 1'b1;
              w_state_nxt = ST_CHECK;
            end
            c_adr_next, c_adr_dc: ;
            default: ;
          endcase
        end
      end
      ST_CHECK: begin
        if (ss_dc[c_dc_null] || (w_beats == '0)) w_state_nxt = ST_DONE;
        else                                     w_state_nxt = ST_WAIT_ROOM;
      end
      ST_WAIT_ROOM: begin
        // Admit a burst only when it can land whole, so the FIFO never overflows
        if (w_free_ext >= w_n) begin
          w_cyc_nxt   = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (m_err) begin
          w_cyc_nxt   = 1'b0;
          w_flush     = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_push && (r_left == 21'd1)) begin
          w_cyc_nxt   = 1'b0;
          w_state_nxt = (r_remain == 21'd1) ? ST_DRAIN : ST_WAIT_ROOM;
        end
      end
      ST_DRAIN: begin
        if (w_empty) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (ss_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_remain <= '0;
      r_left   <= '0;
      r_cyc    <= 1'b0;
      r_c_done <= 1'b0;
      r_ch_err <= 1'b0;
    end else begin
      r_cyc    <= w_cyc_nxt;
      r_c_done <= (w_state_nxt == ST_DONE);
      if (w_load_base) r_addr <= ss_dat[31:3];
      if (w_load_len)  r_len  <= ss_dat[23:0];
      if (r_state == ST_CHECK) r_remain <= w_beats;
      if ((r_state == ST_WAIT_ROOM) && w_cyc_nxt) r_left <= w_n;
      if (w_push) begin
        r_addr   <= r_addr + 29'd1;
        r_remain <= r_remain - 21'd1;
        r_left   <= r_left - 21'd1;
      end
      if ((r_state == ST_BURST) && m_err)
        r_ch_err <= 1'b1;
      else if ((r_state == ST_DONE) && ss_done)
        r_ch_err <= 1'b0;
    end
  end

  ss_fifo #(
    .WIDTH (65),
    .AW    (FIFO_AW)
  ) u_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .flush    (w_flush),
    .push     (w_push),
    .pop      (w_pop),
    .din      ({(r_remain == 21'd1), m_dat64_i, m_dat_i}),
    .dout     (w_dout),
    .empty    (w_empty),
    .full     (w_full),
    .free     (w_free)
  );

  assign c_done   = r_c_done;
  assign ch_err   = r_ch_err;
  assign m_cyc    = r_cyc;
  assign m_stb    = r_cyc;
  assign m_cab    = r_cyc;
  assign m_we     = 1'b0;
  assign m_sel    = {4{r_cyc}};
  assign m_adr    = {r_addr, 3'b000};
  assign st_valid = ~w_empty;
  assign st_data  = st_valid ? w_dout[63:0] : 64'd0;
  assign st_last  = st_valid & w_dout[64];

  assign w_unused_ok = ^{ss_dc[23:7], ss_dc[5:0], w_full};

endmodule
`default_nettype wire

// File: tb/tb_ss_rd_chan.sv
`default_nettype none
// ============================================================================
// tb_ss_rd_chan : randomized bench for ss_rd_chan against a beat-list model
// Rev 1.0
// ============================================================================
module tb_ss_rd_chan;

  localparam int BURST_MAX = 8;
  localparam int FIFO_AW   = 3;
  localparam int DEPTH     = 1 << FIFO_AW;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        ss_we = 1'b0;
  logic [1:0]  ss_adr = '0;
  logic [31:0] ss_dat = '0;
  logic [23:0] ss_dc = '0;
  logic        ss_done = 1'b0;
  logic        c_done, ch_err, m_cyc, m_stb, m_we, m_cab;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat_i, m_dat64_i;
  logic        m_ack = 1'b0, m_err = 1'b0, m_rty = 1'b0;
  logic        st_valid, st_last;
  logic [63:0] st_data;
  logic        st_ready = 1'b0;

  ss_rd_chan #(.BURST_MAX(BURST_MAX), .FIFO_AW(FIFO_AW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .ss_we(ss_we), .ss_adr(ss_adr), .ss_dat(ss_dat), .ss_dc(ss_dc), .ss_done(ss_done),
    .c_done(c_done), .ch_err(ch_err),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_cab(m_cab), .m_sel(m_sel), .m_adr(m_adr),
    .m_dat_i(m_dat_i), .m_dat64_i(m_dat64_i), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .st_valid(st_valid), .st_data(st_data), .st_last(st_last), .st_ready(st_ready)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave memory: read data is a fixed function of the byte address
  function automatic logic [31:0] dlo(input logic [31:0] a);
    return a ^ 32'hC3C3_0F0F;
  endfunction
  function automatic logic [31:0] dhi(input logic [31:0] a);
    return {a[15:0], a[31:16]} + 32'h1111_0001;
  endfunction
  assign m_dat_i   = dlo(m_adr);
  assign m_dat64_i = dhi(m_adr);

  logic [31:0] base;
  logic [63:0] exp_q[$];
  int beats = 0, acks = 0, pops = 0, bursts = 0, burst_acks = 0, rem_start = 0;
  int ack_pct = 100, ready_pct = 100, rty_at = -1, err_at = -1;
  bit prev_cyc = 0, abort = 0, err_seen = 0, rty_done = 0;

  // Wishbone slave, burst framing monitor and stream consumer
  always @(negedge wb_clk_i) begin
    logic [63:0] e;
    if (m_cyc && !prev_cyc) begin
      bursts++;
      burst_acks = 0;
      rem_start  = beats - acks;
    end
    if (!m_cyc && prev_cyc && !abort && !err_seen)
      check("burst_len", 64'(burst_acks), 64'((rem_start < BURST_MAX) ? rem_start : BURST_MAX));
    prev_cyc = m_cyc;
    m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;
    if (m_stb) begin
      check("sel_we", {m_we, m_sel}, 64'h0F);
      if (err_at >= 0 && acks == err_at) begin
        m_err = 1'b1;
        err_seen = 1;
      end else if (rty_at >= 0 && acks == rty_at && !rty_done) begin
        m_rty = 1'b1;
        rty_done = 1;
        check("rty_adr", m_adr, base + 32'(acks) * 8);
      end else if ($urandom_range(99) < ack_pct) begin
        m_ack = 1'b1;
        check("ack_adr", m_adr, base + 32'(acks) * 8);
        check("no_overflow", 64'((acks - pops) < DEPTH), 64'd1);
        acks++;
        burst_acks++;
      end
    end
    st_ready = ($urandom_range(99) < ready_pct);
    if (st_valid && st_ready) begin
      if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("st_data", st_data, e);
        check("st_last", 64'(st_last), 64'(exp_q.size() == 0));
      end
      pops++;
    end
  end

  task automatic load_desc(input logic [31:0] b, input logic [23:0] l, input logic [23:0] dc);
    logic [31:0] a;
    base  = {b[31:3], 3'b000};
    beats = dc[6] ? 0 : int'(((longint'(l) + 7) / 8) % (64'd1 << 21));
    exp_q.delete();
    for (int i = 0; i < beats; i++) begin
      a = base + 32'(i) * 8;
      exp_q.push_back({dhi(a), dlo(a)});
    end
    acks = 0; pops = 0; bursts = 0;
    err_seen = 0; abort = 0; rty_done = 0;
    @(posedge wb_clk_i); #1;
    ss_dc = dc;
    ss_we = 1'b1; ss_adr = 2'd0; ss_dat = $urandom;
    @(posedge wb_clk_i); #1;
    ss_adr = 2'd1; ss_dat = $urandom;
    @(posedge wb_clk_i); #1;
    ss_adr = 2'd2; ss_dat = b;
    @(posedge wb_clk_i); #1;
    ss_adr = 2'd3; ss_dat = {8'($urandom), l};
    @(posedge wb_clk_i); #1;
    ss_we = 1'b0;
  endtask

  task automatic finish_desc(input bit exp_err);
    int n = 0;
    while (!c_done && n < 20000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("c_done_seen", 64'(c_done), 64'd1);
    check("ch_err", 64'(ch_err), 64'(exp_err));
    check("acks", 64'(acks), 64'(exp_err ? err_at : beats));
    if (exp_err) check("pops_err", 64'(pops), 64'd0);
    else begin
      check("bursts", 64'(bursts), 64'((beats + BURST_MAX - 1) / BURST_MAX));
      check("pops", 64'(pops), 64'(beats));
      check("exp_left", 64'(exp_q.size()), 64'd0);
    end
    check("st_valid_done", 64'(st_valid), 64'd0);
    repeat (2) @(negedge wb_clk_i);
    check("c_done_held", {m_cyc, c_done}, 64'd1);
    ss_done = 1'b1;
    @(negedge wb_clk_i);
    ss_done = 1'b0;
    check("done_clr", {c_done, ch_err}, 64'd0);
  endtask

  task automatic wait_cyc();
    int n = 0;
    while (!m_cyc && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("cyc_seen", 64'(m_cyc), 64'd1);
  endtask

  initial begin
    int l;
    repeat (3) @(negedge wb_clk_i);
    check("rst_wb", {m_cyc, m_stb, m_cab, m_we, m_sel, m_adr}, 64'd0);
    check("rst_st", {st_valid, st_last, c_done, ch_err}, 64'd0);
    check("rst_data", st_data, 64'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;

    // Zero-wait 3-beat fetch at 0x1000
    load_desc(32'h0000_1000, 24'd24, 24'd0);
    finish_desc(0);

    // 13 beats split 8 + 5; descriptor writes mid-burst must be ignored
    load_desc($urandom, 24'd100, 24'd0);
    wait_cyc();
    ss_we = 1'b1; ss_adr = 2'd2; ss_dat = 32'hDEAD_BEE8;
    @(negedge wb_clk_i);
    ss_adr = 2'd3; ss_dat = 32'd8;
    @(negedge wb_clk_i);
    ss_we = 1'b0;
    finish_desc(0);

    // Stalled consumer: first burst fills the FIFO, no further cycle until it drains
    ready_pct = 0;
    load_desc($urandom, 24'd256, 24'd0);
    repeat (40) @(negedge wb_clk_i);
    check("stall_bursts", 64'(bursts), 64'd1);
    check("stall_acks", 64'(acks), 64'(DEPTH));
    check("stall_cyc", {m_cyc, 32'(pops)}, 64'd0);
    ready_pct = 100;
    finish_desc(0);

    // Retry on the second beat of a 4-beat fetch
    rty_at = 1;
    load_desc($urandom, 24'd32, 24'd0);
    finish_desc(0);
    check("rty_seen", 64'(rty_done), 64'd1);
    rty_at = -1;

    // Bus error on the first beat
    err_at = 0;
    load_desc($urandom, 24'd64, 24'd0);
    finish_desc(1);
    err_at = -1;

    // Null descriptor: no fetch, c_done two cycles after the length write
    load_desc($urandom, 24'd64, 24'h000040);
    @(negedge wb_clk_i);
    check("null_c_done_early", 64'(c_done), 64'd0);
    @(negedge wb_clk_i);
    check("null_c_done", 64'(c_done), 64'd1);
    finish_desc(0);

    // Asynchronous reset mid-burst
    load_desc($urandom, 24'd256, 24'd0);
    wait_cyc();
    abort = 1;
    #2 wb_rst_i = 1'b1;
    #1 check("rst_async", {m_cyc, m_stb, st_valid, c_done}, 64'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    check("rst_stays_idle", {m_cyc, st_valid, c_done}, 64'd0);

    // Randomized descriptors
    for (int i = 0; i < 25; i++) begin
      ack_pct   = $urandom_range(100, 30);
      ready_pct = $urandom_range(100, 20);
      l         = $urandom_range(300, 0);
      rty_at    = ($urandom_range(2) == 0) ? $urandom_range(l / 8, 0) : -1;
      load_desc($urandom, 24'(l), ($urandom_range(7) == 0) ? 24'h000040 : (24'($urandom) & 24'hFFFFBF));
      finish_desc(0);
    end
    rty_at = -1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ss_rd_chan.md
Name: ss_rd_chan

Overview:
- Source-side DMA channel. Sits directly downstream of the descriptor controller's per-channel slot interface (ss_we/ss_adr/ss_dat/ss_dc/ss_done in, c_done out).
- Latches a buffer descriptor, then fetches the buffer over a 64-bit Wishbone master in bursts.
- Buffers fetched beats in an internal FIFO and presents them on a valid/ready stream to the engine core.
- Reports completion back to the controller on c_done.

Parameters:
- BURST_MAX, 8, maximum beats per Wishbone cycle (power of 2, 2..16).
- FIFO_AW, 4, log2 of FIFO depth in 64-bit beats; depth must be >= BURST_MAX.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- ss_we  in  1  descriptor word write strobe
- ss_adr  in  2  descriptor word index: 0 next ptr (ignored), 1 dc (ignored), 2 buffer address, 3 byte length
- ss_dat  in  32  descriptor word data
- ss_dc  in  24  descriptor control; bit 6 = null descriptor (no fetch)
- ss_done  in  1  controller acknowledge of completion, 1-cycle pulse
- c_done  out  1  channel finished; level
- ch_err  out  1  bus error on last descriptor; level, valid with c_done
- m_cyc, m_stb, m_we, m_cab  out  1 each  Wishbone master controls (m_we always 0)
- m_sel  out  4  byte select, always 4'b1111 when m_stb
- m_adr  out  32  byte address, bits [2:0] = 0
- m_dat_i, m_dat64_i  in  32 each  read data low/high word
- m_ack, m_err, m_rty  in  1 each  slave responses
- st_valid  out  1  stream beat valid
- st_data  out  64  {m_dat64_i, m_dat_i} as captured
- st_last  out  1  final beat of descriptor
- st_ready  in  1  consumer accept

Behaviour:
- Reset: all outputs 0. State IDLE, FIFO empty, address and length registers 0.
- Descriptor load, IDLE only:
  - ss_we with adr 2 latches base[31:3] = ss_dat[31:3].
  - ss_we with adr 3 latches len = ss_dat[23:0] and moves to CHECK next cycle.
  - Writes in any other state are ignored.
- Beat count = ceil(len/8), computed in 21 bits. A partial final beat is transferred whole; the consumer trims it.
- CHECK:
  - ss_dc[6]=1 or beat count 0 -> DONE.
  - Otherwise -> WAIT_ROOM.
- WAIT_ROOM:
  - n = min(remaining, BURST_MAX).
  - When FIFO free >= n, assert m_cyc=m_stb=m_cab=1, m_adr={addr,3'b0}; -> BURST.
- BURST:
  - Each m_ack (without err/rty) pushes one beat into the FIFO, addr += 1 (8 bytes, wraps mod 2^32), remaining -= 1.
  - st_last tag is set when remaining was 1.
  - The cycle after the n-th ack: m_cyc=m_stb=m_cab=0. Go to WAIT_ROOM if remaining != 0, else DRAIN.
  - m_rty: no push, stb held, same address reissued.
  - m_err: drop cyc/stb next cycle, set ch_err, discard FIFO contents -> DONE.
  - Any combination of ack with err/rty is treated as err when err is set, otherwise as rty.
- Registered master outputs: ack in cycle k deasserts stb in cycle k+1. The slave must not ack in that cycle.
- DRAIN: wait until FIFO empty and the last beat has been accepted -> DONE.
- DONE:
  - c_done=1 and held.
  - On ss_done: clear c_done and ch_err -> IDLE next cycle.
  - ss_done in any other state is ignored.
- Stream:
  - st_valid = FIFO not empty; st_data/st_last come from the FIFO head.
  - Pop on st_valid & st_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full; the WAIT_ROOM admission check guarantees this.
- Reset mid-burst: cyc/stb drop immediately (async), FIFO is flushed, and the descriptor must be reloaded.

Decomposition:
- Shared package: state encodings (IDLE, CHECK, WAIT_ROOM, BURST, DRAIN, DONE), descriptor word indices, and the DC_NULL bit position (6).
- Sub-module ss_fifo:
  - Synchronous FIFO, width 65, depth 2^FIFO_AW.
  - Ports: push, pop, din, dout, empty, full, free count.
  - Async reset clears pointers.

Test Plan:
- Load adr2=0x1000, adr3=24, st_ready=1, zero-wait ack -> one burst of 3 beats at 0x1000/0x1008/0x1010, st_last on beat 3, c_done=1 after the last pop, cleared the cycle after the ss_done pulse.
- len=100 (13 beats), BURST_MAX=8 -> two cycles of 8 then 5 beats, m_cyc low for at least 1 cycle between them, 13 stream beats in order.
- st_ready=0, FIFO_AW=3, len=256 -> first burst of 8 fills the FIFO, no new m_cyc until 8 pops; total 32 beats with no loss or duplication.
- m_rty on beat 2 of a 4-beat fetch -> address 0x...08 reissued, exactly 4 beats pushed.
- m_err on beat 1 -> cyc drops, ch_err=1 with c_done=1, no st_valid; ss_done clears both.
- ss_dc[6]=1 with len=64 -> no m_cyc, c_done=1 two cycles after the adr3 write; ss_we during BURST is ignored.
